// File: rtl/pixel_write_scheduler.sv
// rtl/pixel_write_scheduler.sv - single-port pixel RAM arbiter: VGA reads, queued plotter writes, clear-screen
module pixel_write_scheduler #(
  parameter int NUM_PIXELS = 307200,
  parameter int ADDR_W     = 19,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              wr_data,
  input  logic              clear_req,
  output logic              clear_busy,
  input  logic              vga_active,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wEn,
  output logic              ram_dataIn,
  output logic [CNT_W-1:0]  fifo_count,
  output logic [15:0]       drop_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] NUM_C   = ADDR_W'(NUM_PIXELS);
  localparam logic [ADDR_W-1:0] LAST_C  = ADDR_W'(NUM_PIXELS - 1);

  typedef enum logic [1:0] {IDLE, DRAIN, CLEAR} state_t;

  state_t            state;
  logic [ADDR_W-1:0] q_addr [FIFO_DEPTH];
  logic              q_data [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [ADDR_W-1:0] clr_addr;
  logic [CNT_W-1:0]  count_next;
  logic [ADDR_W-1:0] head_addr;
  logic              head_data;
  logic              head_ok;
  logic              push;
  logic              pop;

  // No full-bypass: a full queue refuses pushes even when the head pops this cycle.
  assign wr_ready   = (fifo_count < DEPTH_C) && (state != CLEAR);
  assign push       = wr_valid && wr_ready;
  assign pop        = (state == DRAIN) && !vga_active;
  assign head_addr  = q_addr[rd_ptr];
  assign head_data  = q_data[rd_ptr];
  assign head_ok    = head_addr < NUM_C;
  assign clear_busy = (state == CLEAR);

  // Occupancy after this edge; simultaneous push and pop cancel out.
  always_comb begin
    count_next = fifo_count;
    case ({push, pop})
      2'b10:   count_next = fifo_count + 1'b1;
      2'b01:   count_next = fifo_count - 1'b1;
      default: count_next = fifo_count;
    endcase
  end

  // RAM port mux: VGA first, then clear sweep, then queue head; data forced low when not writing.
  always_comb begin
    ram_addr   = vga_addr;
    ram_wEn    = 1'b0;
    ram_dataIn = 1'b0;
    if (vga_active) begin
      ram_addr = vga_addr;
    end else if (state == CLEAR) begin
      ram_addr = clr_addr;
      ram_wEn  = 1'b1;
    end else if (fifo_count != '0) begin
      ram_addr   = head_addr;
      ram_wEn    = head_ok;
      ram_dataIn = head_ok ? head_data : 1'b0;
    end
  end

  // Queue storage; entries are only read back through the head pointer.
  always_ff @(posedge clock) begin
    if (push) begin
      q_addr[wr_ptr] <= wr_addr;
      q_data[wr_ptr] <= wr_data;
    end
  end

  // Scheduler state, queue pointers, clear sweep counter and drop statistics.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      fifo_count <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      clr_addr   <= '0;
      drop_count <= '0;
    end else begin
      fifo_count <= count_next;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (pop && !head_ok && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
      case (state)
        IDLE: begin
          if (clear_req) begin
            state    <= CLEAR;
            clr_addr <= '0;
          end else if (push) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (clear_req) begin
            state    <= CLEAR;
            clr_addr <= '0;
          end else if (count_next == '0) begin
            state <= IDLE;
          end
        end
        CLEAR: begin
          // The sweep only advances on cycles the VGA leaves the port free.
          if (!vga_active) begin
            if (clr_addr == LAST_C) begin
              clr_addr <= '0;
              state    <= (count_next != '0) ? DRAIN : IDLE;
            end else begin
              clr_addr <= clr_addr + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_write_scheduler.sv
// tb/tb_pixel_write_scheduler.sv - self-checking bench for pixel_write_scheduler
module tb_pixel_write_scheduler;
  localparam int NP = 16;
  localparam int AW = 5;
  localparam int FD = 4;
  localparam int CW = 3;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [AW-1:0] wr_addr = '0;
  logic          wr_data = 1'b0;
  logic          clear_req = 1'b0;
  logic          clear_busy;
  logic          vga_active = 1'b0;
  logic [AW-1:0] vga_addr = '0;
  logic [AW-1:0] ram_addr;
  logic          ram_wEn;
  logic          ram_dataIn;
  logic [CW-1:0] fifo_count;
  logic [15:0]   drop_count;

  int errors = 0;
  int checks = 0;
  int nwrites = 0;
  logic [AW:0] exp_q[$];
  logic [AW:0] exp_e;

  pixel_write_scheduler #(
    .NUM_PIXELS(NP), .ADDR_W(AW), .FIFO_DEPTH(FD), .CNT_W(CW)
  ) dut (
    .clock(clock), .reset(reset),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .clear_req(clear_req), .clear_busy(clear_busy),
    .vga_active(vga_active), .vga_addr(vga_addr),
    .ram_addr(ram_addr), .ram_wEn(ram_wEn), .ram_dataIn(ram_dataIn),
    .fifo_count(fifo_count), .drop_count(drop_count)
  );

  always #5 clock = ~clock;

  // Scoreboard: every RAM write must match the next expected {addr,data}.
  always @(negedge clock) begin
    if (ram_wEn === 1'b1) begin
      nwrites++;
      checks++;
      if (vga_active !== 1'b0) begin
        errors++;
        $display("FAIL write_vs_vga: ram_wEn=1 with vga_active=%b, required no write", vga_active);
      end
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: addr=%0d data=%b, required no write", ram_addr, ram_dataIn);
      end else begin
        exp_e = exp_q.pop_front();
        if ({ram_addr, ram_dataIn} !== exp_e) begin
          errors++;
          $display("FAIL write_order: addr=%0d data=%b, required addr=%0d data=%b",
                   ram_addr, ram_dataIn, exp_e[AW:1], exp_e[0]);
        end
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic push_clear_exp(input int upto);
    logic [AW-1:0] a;
    for (int i = 0; i < upto; i++) begin
      a = AW'(i);
      exp_q.push_back({a, 1'b0});
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    @(negedge clock);
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d, required 0", fifo_count); end
    checks++; if (clear_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, required 0", clear_busy); end
    checks++; if (ram_wEn !== 1'b0) begin errors++; $display("FAIL reset_wen: got %b, required 0", ram_wEn); end
    checks++; if (drop_count !== 16'd0) begin errors++; $display("FAIL reset_drop: got %0d, required 0", drop_count); end
    step();
    reset = 1'b0;
  endtask

  task automatic test_single_write();
    vga_active = 1'b0;
    wr_valid = 1'b1; wr_addr = 5'd3; wr_data = 1'b1;
    exp_q.push_back({5'd3, 1'b1});
    @(negedge clock);
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL single_ready: got %b, required 1", wr_ready); end
    step();
    wr_valid = 1'b0;
    @(negedge clock);
    checks++; if (fifo_count !== 3'd1) begin errors++; $display("FAIL single_count1: got %0d, required 1", fifo_count); end
    checks++; if (ram_wEn !== 1'b1 || ram_addr !== 5'd3 || ram_dataIn !== 1'b1) begin
      errors++; $display("FAIL single_write: wen=%b addr=%0d data=%b, required 1/3/1", ram_wEn, ram_addr, ram_dataIn);
    end
    step();
    @(negedge clock);
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL single_count0: got %0d, required 0", fifo_count); end
    checks++; if (ram_wEn !== 1'b0) begin errors++; $display("FAIL single_idle_wen: got %b, required 0", ram_wEn); end
    step();
  endtask

  task automatic test_back_to_back();
    int base;
    logic [AW-1:0] a;
    logic d;
    vga_active = 1'b1; vga_addr = 5'd9;
    for (int i = 0; i < 5; i++) begin
      a = AW'(10 + i); d = i[0];
      wr_valid = 1'b1; wr_addr = a; wr_data = d;
      @(negedge clock);
      checks++; if (wr_ready !== (i < FD)) begin errors++; $display("FAIL b2b_ready%0d: got %b, required %b", i, wr_ready, (i < FD)); end
      checks++; if (ram_wEn !== 1'b0) begin errors++; $display("FAIL b2b_wen_vga%0d: got %b, required 0", i, ram_wEn); end
      if (i < FD) exp_q.push_back({a, d});
      step();
    end
    wr_valid = 1'b0;
    @(negedge clock);
    checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL b2b_full: got %0d, required 4", fifo_count); end
    checks++; if (ram_addr !== 5'd9) begin errors++; $display("FAIL b2b_vga_addr: got %0d, required 9", ram_addr); end
    step();
    base = nwrites;
    vga_active = 1'b0;
    repeat (4) step();
    checks++; if (nwrites - base !== 4) begin errors++; $display("FAIL b2b_drain: got %0d writes, required 4", nwrites - base); end
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL b2b_empty: got %0d, required 0", fifo_count); end
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL b2b_sb: got %0d pending, required 0", exp_q.size()); end
  endtask

  task automatic test_clear();
    int base;
    int busy;
    bit done;
    vga_active = 1'b1;
    wr_valid = 1'b1; wr_addr = 5'd1; wr_data = 1'b1;
    step();
    wr_addr = 5'd2; wr_data = 1'b1;
    step();
    wr_valid = 1'b0;
    clear_req = 1'b1;
    push_clear_exp(NP);
    exp_q.push_back({5'd1, 1'b1});
    exp_q.push_back({5'd2, 1'b1});
    step();
    clear_req = 1'b0;
    vga_active = 1'b0;
    base = nwrites;
    busy = 0; done = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clock);
      if (clear_busy === 1'b1) begin
        busy++;
        checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL clear_ready: got %b, required 0", wr_ready); end
      end else begin
        done = 1'b1;
      end
    end
    checks++; if (!done) begin errors++; $display("FAIL clear_timeout: clear_busy still %b, required 0", clear_busy); end
    checks++; if (busy !== NP) begin errors++; $display("FAIL clear_len: got %0d cycles, required %0d", busy, NP); end
    step();
    step();
    checks++; if (nwrites - base !== NP + 2) begin errors++; $display("FAIL clear_writes: got %0d, required %0d", nwrites - base, NP + 2); end
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL clear_fifo: got %0d, required 0", fifo_count); end
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL clear_sb: got %0d pending, required 0", exp_q.size()); end
  endtask

  task automatic test_clear_vga_pause();
    int base;
    bit done;
    vga_active = 1'b0;
    clear_req = 1'b1;
    push_clear_exp(NP);
    base = nwrites;
    step();
    clear_req = 1'b0;
    repeat (7) step();
    vga_active = 1'b1; vga_addr = 5'd30;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      checks++; if (ram_wEn !== 1'b0 || clear_busy !== 1'b1) begin
        errors++; $display("FAIL pause_hold%0d: wen=%b busy=%b, required 0/1", k, ram_wEn, clear_busy);
      end
      step();
    end
    vga_active = 1'b0;
    @(negedge clock);
    checks++; if (ram_addr !== 5'd7 || ram_wEn !== 1'b1) begin
      errors++; $display("FAIL pause_resume: addr=%0d wen=%b, required 7/1", ram_addr, ram_wEn);
    end
    done = 1'b0;
    for (int k = 0; k < 30 && !done; k++) begin
      @(negedge clock);
      if (clear_busy !== 1'b1) done = 1'b1;
    end
    checks++; if (!done) begin errors++; $display("FAIL pause_timeout: clear_busy still %b, required 0", clear_busy); end
    checks++; if (nwrites - base !== NP) begin errors++; $display("FAIL pause_total: got %0d, required %0d", nwrites - base, NP); end
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL pause_sb: got %0d pending, required 0", exp_q.size()); end
    step();
  endtask

  task automatic test_out_of_range();
    vga_active = 1'b0;
    wr_valid = 1'b1; wr_addr = 5'd20; wr_data = 1'b1;
    step();
    wr_addr = 5'd6; wr_data = 1'b1;
    exp_q.push_back({5'd6, 1'b1});
    @(negedge clock);
    checks++; if (ram_wEn !== 1'b0 || ram_dataIn !== 1'b0) begin
      errors++; $display("FAIL oor_nowrite: wen=%b data=%b, required 0/0", ram_wEn, ram_dataIn);
    end
    checks++; if (ram_addr !== 5'd20) begin errors++; $display("FAIL oor_addr: got %0d, required 20", ram_addr); end
    step();
    wr_valid = 1'b0;
    @(negedge clock);
    checks++; if (drop_count !== 16'd1) begin errors++; $display("FAIL oor_drop: got %0d, required 1", drop_count); end
    checks++; if (ram_wEn !== 1'b1) begin errors++; $display("FAIL oor_next: got wen=%b, required 1", ram_wEn); end
    step();
    checks++; if (exp_q.size() !== 0 || fifo_count !== 3'd0) begin
      errors++; $display("FAIL oor_done: pending=%0d count=%0d, required 0/0", exp_q.size(), fifo_count);
    end
  endtask

  task automatic test_reset_mid_clear();
    int base;
    bit done;
    vga_active = 1'b1;
    wr_valid = 1'b1; wr_addr = 5'd4; wr_data = 1'b1;
    step();
    wr_addr = 5'd5; wr_data = 1'b0;
    step();
    wr_valid = 1'b0;
    clear_req = 1'b1;
    push_clear_exp(10);
    step();
    clear_req = 1'b0;
    vga_active = 1'b0;
    repeat (9) step();
    reset = 1'b1;
    @(negedge clock);
    checks++; if (ram_addr !== 5'd9) begin errors++; $display("FAIL rst_at9: got %0d, required 9", ram_addr); end
    step();
    @(negedge clock);
    checks++; if (clear_busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b, required 0", clear_busy); end
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL rst_fifo: got %0d, required 0", fifo_count); end
    checks++; if (ram_wEn !== 1'b0) begin errors++; $display("FAIL rst_wen: got %b, required 0", ram_wEn); end
    checks++; if (drop_count !== 16'd0) begin errors++; $display("FAIL rst_drop: got %0d, required 0", drop_count); end
    step();
    reset = 1'b0;
    clear_req = 1'b1;
    push_clear_exp(NP);
    base = nwrites;
    step();
    clear_req = 1'b0;
    @(negedge clock);
    checks++; if (ram_addr !== 5'd0 || ram_wEn !== 1'b1) begin
      errors++; $display("FAIL rst_restart: addr=%0d wen=%b, required 0/1", ram_addr, ram_wEn);
    end
    done = 1'b0;
    for (int k = 0; k < 30 && !done; k++) begin
      @(negedge clock);
      if (clear_busy !== 1'b1) done = 1'b1;
    end
    checks++; if (!done) begin errors++; $display("FAIL rst_timeout: clear_busy still %b, required 0", clear_busy); end
    checks++; if (nwrites - base !== NP) begin errors++; $display("FAIL rst_total: got %0d, required %0d", nwrites - base, NP); end
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL rst_sb: got %0d pending, required 0", exp_q.size()); end
    step();
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_back_to_back();
    test_clear();
    test_clear_vga_pause();
    test_out_of_range();
    test_reset_mid_clear();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pixel_write_scheduler.md
Name: pixel_write_scheduler

Overview:
- Owns the single port of the 1-bit, 640x480 pixel RAM and shares it between two users: the VGA controller, which reads, and a CPU-side plotter, which writes.
- The VGA controller always has priority. Plotter writes are queued in a small FIFO and committed only while the VGA is not fetching.
- A sequenced clear-screen operation zeroes every pixel address.
- Sits between the VGA controller, the processor I/O path and the pixel RAM in the top-level FPGA wrapper.

Parameters:
- NUM_PIXELS, 307200, number of addressable pixels (640*480).
- ADDR_W, 19, pixel address width.
- FIFO_DEPTH, 8, plotter write queue entries (power of 2).
- CNT_W, 4, width of fifo_count; holds 0..FIFO_DEPTH.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- wr_valid  in  1  plotter write request.
- wr_ready  out  1  scheduler can accept a write this cycle.
- wr_addr  in  ADDR_W  pixel address of the request.
- wr_data  in  1  pixel value of the request.
- clear_req  in  1  single-cycle pulse; start clear-screen.
- clear_busy  out  1  clear-screen in progress.
- vga_active  in  1  VGA controller needs the RAM port this cycle.
- vga_addr  in  ADDR_W  VGA read address.
- ram_addr  out  ADDR_W  pixel RAM address.
- ram_wEn  out  1  pixel RAM write enable.
- ram_dataIn  out  1  pixel RAM write data.
- fifo_count  out  CNT_W  entries currently queued.
- drop_count  out  16  saturating count of discarded out-of-range writes.

Behaviour:
- Reset: state=IDLE, FIFO emptied, fifo_count=0, clear address counter=0, drop_count=0, clear_busy=0, ram_wEn=0.
- Reset also aborts a clear in progress; no further writes are issued after the reset edge.

State machine:
- IDLE: fifo_count==0, no writes issued. clear_req goes to CLEAR; an accepted push goes to DRAIN.
- DRAIN: fifo_count>0. Stays in DRAIN until the last entry pops, then goes to IDLE. clear_req goes to CLEAR; the FIFO contents are kept.
- CLEAR: clear address counter runs 0..NUM_PIXELS-1. After the write at NUM_PIXELS-1 commits, goes to DRAIN if fifo_count>0, else IDLE.
- Queued writes therefore land on top of the cleared screen.
- clear_req is ignored while already in CLEAR.
- clear_busy=1 exactly while in CLEAR.

Enqueue:
- wr_ready = (fifo_count < FIFO_DEPTH) and (state != CLEAR).
- A push occurs on a clock edge where wr_valid && wr_ready.
- When the FIFO is full, wr_ready=0 even if a pop occurs in the same cycle (no full-bypass).
- A push and a pop in the same cycle leave fifo_count unchanged.

Port mux (combinational):
- If vga_active: ram_addr=vga_addr, ram_wEn=0.
- Else if CLEAR: ram_addr=clear address, ram_dataIn=0, ram_wEn=1.
- Else if fifo_count>0: ram_addr=head addr, ram_dataIn=head data, ram_wEn=(head addr < NUM_PIXELS).
- Else: ram_addr=vga_addr, ram_wEn=0.
- ram_dataIn=0 whenever ram_wEn=0.

Commit / pop:
- In DRAIN with vga_active=0, the head entry pops at the clock edge.
- If the head addr >= NUM_PIXELS, the entry pops with no write and drop_count increments, saturating at 16'hFFFF.
- In CLEAR with vga_active=0, the clear address counter increments.
- The clear address counter holds its value while vga_active=1.

Latency and ordering:
- Minimum latency is 1 cycle: a push at edge N is written to RAM during cycle N+1 if vga_active=0.
- Writes commit in FIFO order.
- No write is ever asserted in a cycle with vga_active=1.

Test Plan:
Benches use NUM_PIXELS=16, ADDR_W=5, FIFO_DEPTH=4, CNT_W=3.
1. Reset, vga_active=0, push (addr 3, data 1) -> next cycle ram_addr=3, ram_wEn=1, ram_dataIn=1; fifo_count returns 1->0; state returns to IDLE.
2. vga_active=1, push 5 entries back-to-back -> wr_ready drops after the 4th, fifo_count=4, ram_wEn=0 throughout; release vga_active -> 4 writes commit in order over 4 cycles.
3. clear_req with vga_active=0 -> clear_busy=1 for 16 cycles, writes of 0 to addr 0..15 in order; wr_ready=0 during CLEAR; the 2 previously queued entries commit immediately after the write to addr 15.
4. During CLEAR, toggle vga_active=1 for 3 cycles at addr 7 -> no write in those cycles, counter holds at 7, clear resumes at 7, total clear writes=16.
5. Push addr 20 (out of range) -> pops with ram_wEn=0, drop_count=1; an adjacent in-range entry still commits.
6. Assert reset at clear address 9 -> next cycle clear_busy=0, fifo_count=0, ram_wEn=0; a new clear_req restarts at address 0.
